// File: rtl/fpna_config_loader_if.sv
// Configuration bus between the neurochip config loader and its surroundings.
// Carries the serial bitstream, the shadow-register write port and status flags.
interface fpna_config_loader_if #(
    parameter int CFG_W  = 8,
    parameter int ADDR_W = 3
);
    // Handshake: config_en is the qualifier (valid) for bs_in on every rising
    // edge. There is no ready: the loader takes every qualified bit while it is
    // idle or loading; during commit the bit is not assembled; in drain it is
    // forwarded on bs_out one cycle later. cfg_we and cfg_commit are
    // single-cycle strobes that the shadow/active register file must accept
    // unconditionally.
    logic              config_en;
    logic              bs_in;
    logic              bs_out;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CFG_W-1:0]  cfg_data;
    logic              cfg_we;
    logic              cfg_commit;
    logic              cfg_done;
    logic              cfg_error;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        output config_en,
        output bs_in,
        input  bs_out,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_we,
        input  cfg_commit,
        input  cfg_done,
        input  cfg_error,
        input  busy,
        input  state_dbg
    );

    modport slave (
        input  config_en,
        input  bs_in,
        output bs_out,
        output cfg_addr,
        output cfg_data,
        output cfg_we,
        output cfg_commit,
        output cfg_done,
        output cfg_error,
        output busy,
        output state_dbg
    );
endinterface

// File: rtl/fpna_config_loader.sv
// Serial configuration loader: assembles a frame of NUM_CELLS words into the
// shadow registers, pulses a commit, and forwards surplus bits down the chain.
module fpna_config_loader #(
    parameter int NUM_CELLS = 8,
    parameter int CFG_W     = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    fpna_config_loader_if.slave   bus
);
    localparam int BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CFG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [ADDR_W-1:0]   word_cnt, word_cnt_d;
    // Holds the CFG_W-1 bits already received of the current word.
    logic [CFG_W-2:0]    sr, sr_d;
    logic [CFG_W-1:0]    word_next;
    logic                accept;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CFG_W-1:0]    data_q, data_d;
    logic                we_q, we_d;
    logic                commit_q, commit_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                bs_out_q, bs_out_d;

    assign accept    = bus.config_en && ((state == IDLE) || (state == LOAD));
    assign word_next = {sr, bus.bs_in};

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        word_cnt_d = word_cnt;
        sr_d       = sr;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        commit_d   = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
        bs_out_d   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.config_en) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Early end: abandon the partial frame so the next session
                // restarts from word 0, bit 0.
                if (!bus.config_en) begin
                    error_d    = 1'b1;
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    sr_d       = '0;
                end
            end
            COMMIT: begin
                commit_d = 1'b1;
                if (bus.config_en) begin
                    state_d  = DRAIN;
                    bs_out_d = bus.bs_in;
                end else begin
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (bus.config_en) begin
                    bs_out_d = bus.bs_in;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sr_d = word_next[CFG_W-2:0];
            if (bit_cnt == LAST_BIT) begin
                bit_cnt_d = '0;
                addr_d    = word_cnt;
                data_d    = word_next;
                we_d      = 1'b1;
                if (word_cnt == LAST_WORD) begin
                    word_cnt_d = '0;
                    state_d    = COMMIT;
                end else begin
                    word_cnt_d = word_cnt + ADDR_W'(1);
                end
            end else begin
                bit_cnt_d = bit_cnt + BIT_W'(1);
            end
        end

        // cfg_done follows the commit pulse by one cycle, unless a new
        // session is opening in that same cycle.
        if (commit_q && !((state == IDLE) && bus.config_en)) begin
            done_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            sr       <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            commit_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            bs_out_q <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            word_cnt <= word_cnt_d;
            sr       <= sr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            commit_q <= commit_d;
            done_q   <= done_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            bs_out_q <= bs_out_d;
        end
    end

    assign bus.cfg_addr   = addr_q;
    assign bus.cfg_data   = data_q;
    assign bus.cfg_we     = we_q;
    assign bus.cfg_commit = commit_q;
    assign bus.cfg_done   = done_q;
    assign bus.cfg_error  = error_q;
    assign bus.busy       = busy_q;
    assign bus.bs_out     = bs_out_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_fpna_config_loader.sv
// Bench for fpna_config_loader: directed sessions and random-length sessions
// checked cycle by cycle against a frame-level model of the config protocol.
module tb_fpna_config_loader;
    localparam int NUM_CELLS = 8;
    localparam int CFG_W     = 8;
    localparam int ADDR_W    = 3;
    localparam int FRAME     = NUM_CELLS * CFG_W;
    localparam int MAXC      = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpna_config_loader_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) bus ();

    fpna_config_loader #(
        .NUM_CELLS(NUM_CELLS),
        .CFG_W(CFG_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]          byte_a [16];
    logic                en_a   [MAXC];
    logic                bit_a  [MAXC];
    logic                obs_we [MAXC];
    logic [ADDR_W-1:0]   obs_addr [MAXC];
    logic [CFG_W-1:0]    obs_data [MAXC];
    logic                obs_commit [MAXC];
    logic                obs_done [MAXC];
    logic                obs_error [MAXC];
    logic                obs_busy [MAXC];
    logic                obs_bs_out [MAXC];
    logic [ADDR_W+CFG_W-1:0] exp_q[$];

    task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic randomize_bytes();
        for (int i = 0; i < 16; i++) byte_a[i] = 8'($urandom_range(0, 255));
    endtask

    // config_en high for the first run_len cycles; bits come MSB first from byte_a.
    task automatic build(input int run_len);
        for (int t = 0; t < MAXC; t++) begin
            logic [7:0] b;
            b        = byte_a[t / 8];
            en_a[t]  = (t < run_len);
            bit_a[t] = b[7 - (t % 8)];
        end
    endtask

    task automatic run_window(input int n);
        for (int t = 0; t < n; t++) begin
            bus.config_en = en_a[t];
            bus.bs_in     = bit_a[t];
            @(posedge clk);
            #1;
            obs_we[t]     = bus.cfg_we;
            obs_addr[t]   = bus.cfg_addr;
            obs_data[t]   = bus.cfg_data;
            obs_commit[t] = bus.cfg_commit;
            obs_done[t]   = bus.cfg_done;
            obs_error[t]  = bus.cfg_error;
            obs_busy[t]   = bus.busy;
            obs_bs_out[t] = bus.bs_out;
        end
        bus.config_en = 1'b0;
        bus.bs_in     = 1'b0;
    endtask

    // Frame-level model: a session is one run of config_en starting at t=0.
    // Word w is written after its last bit; a run of at least FRAME bits commits
    // the cycle after the last write, then surplus bits pass through.
    task automatic check_window(input string tag, input int n);
        int  run_len;
        int  n_words;
        bit  full;
        logic [ADDR_W+CFG_W-1:0] e;
        run_len = 0;
        while (run_len < n && en_a[run_len]) run_len++;
        full    = (run_len >= FRAME);
        n_words = (full ? FRAME : run_len) / CFG_W;
        exp_q.delete();
        for (int w = 0; w < n_words; w++) exp_q.push_back({ADDR_W'(w), byte_a[w]});
        for (int t = 0; t < n; t++) begin
            logic exp_we;
            logic exp_bs;
            exp_we = (t < run_len) && (t < FRAME) && (((t + 1) % CFG_W) == 0);
            exp_bs = (t >= FRAME && t < run_len) ? bit_a[t] : 1'b0;
            chk({tag, ".we"}, t, obs_we[t], exp_we);
            if (obs_we[t]) begin
                chk({tag, ".wr_expected"}, t, (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({tag, ".wr_addr_data"}, t, {obs_addr[t], obs_data[t]}, e);
                end
            end
            chk({tag, ".commit"}, t, obs_commit[t], full && (t == FRAME));
            chk({tag, ".done"},   t, obs_done[t],   full && (t >= FRAME + 1));
            chk({tag, ".error"},  t, obs_error[t],  !full && (t >= run_len));
            chk({tag, ".busy"},   t, obs_busy[t],   (t < run_len));
            chk({tag, ".bs_out"}, t, obs_bs_out[t], exp_bs);
        end
        chk({tag, ".writes_left"}, n, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_reset(input string tag);
        bus.config_en = 1'b0;
        bus.bs_in     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".we"},     0, bus.cfg_we, 0);
        chk({tag, ".addr"},   0, bus.cfg_addr, 0);
        chk({tag, ".data"},   0, bus.cfg_data, 0);
        chk({tag, ".commit"}, 0, bus.cfg_commit, 0);
        chk({tag, ".done"},   0, bus.cfg_done, 0);
        chk({tag, ".error"},  0, bus.cfg_error, 0);
        chk({tag, ".busy"},   0, bus.busy, 0);
        chk({tag, ".bs_out"}, 0, bus.bs_out, 0);
        reset = 1'b0;
    endtask

    initial begin
        int len;
        reset         = 1'b1;
        bus.config_en = 1'b0;
        bus.bs_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset("reset0");

        // Full frame 0x01..0x08, config_en falls in the commit cycle.
        randomize_bytes();
        for (int i = 0; i < 8; i++) byte_a[i] = 8'(i + 1);
        build(FRAME);
        run_window(72);
        check_window("frame_seq", 72);

        // Early end after 20 bits.
        randomize_bytes();
        build(20);
        run_window(26);
        check_window("early_end", 26);

        // Full session right after an error: error clears, done sets.
        randomize_bytes();
        build(FRAME);
        run_window(70);
        check_window("after_err", 70);

        // Frame plus 16 surplus bits 0xA5C3 forwarded on bs_out.
        randomize_bytes();
        byte_a[8] = 8'hA5;
        byte_a[9] = 8'hC3;
        build(FRAME + 16);
        run_window(FRAME + 20);
        check_window("daisy", FRAME + 20);

        // Reset at bit 30, then a full frame 0xFF..0xF8.
        randomize_bytes();
        build(30);
        run_window(30);
        check_window("pre_reset", 30);
        apply_reset("mid_reset");
        for (int i = 0; i < 8; i++) byte_a[i] = 8'hFF - 8'(i);
        build(FRAME);
        run_window(70);
        check_window("post_reset", 70);

        // config_en dropped in the commit cycle with noisy bs_in afterwards.
        randomize_bytes();
        build(FRAME);
        run_window(72);
        check_window("drop_commit", 72);

        // Random session lengths covering early end, exact frame and drain.
        for (int k = 0; k < 8; k++) begin
            randomize_bytes();
            len = $urandom_range(1, 90);
            build(len);
            run_window((len + 4 > 68) ? len + 4 : 68);
            check_window("random", (len + 4 > 68) ? len + 4 : 68);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
